// File: rtl/spi_pkg.sv
// Shared state encodings and frame-sizing helpers for the SPI TX serializer.
// Build option: define SER_PARITY_EN to append an even-parity bit to every frame.
package spi_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    function automatic int frame_len(input int data_w);
`ifdef SER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    function automatic int cnt_width(input int fl);
        return (fl > 1) ? $clog2(fl) : 1;
    endfunction

endpackage

// File: rtl/spi_tx_holdbuf.sv
// One-entry holding register between the TX word source and the serializer.
// Ready depends only on the full flag, so there is no combinational path from push_valid.
module spi_tx_holdbuf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              buf_full,
    output logic [DATA_W-1:0] buf_data
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Push only happens while empty and pop only while full, so they never collide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop) begin
            full_d = 1'b0;
        end else if (push_valid && !full_q) begin
            full_d = 1'b1;
            data_d = push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign push_ready = !full_q;
    assign buf_full   = full_q;
    assign buf_data   = data_q;

endmodule

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial SPI transmitter: one-entry buffer, frame shift register and IDLE/SHIFT FSM.
// Build option: SER_PARITY_EN appends an even-parity bit after the data bits.
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              shift_en,
    output logic              serial_out,
    output logic              busy,
    output logic              last_bit,
    output logic              done
);

    localparam int             FL       = frame_len(DATA_W);
    localparam int             CW       = cnt_width(FL);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FL - 1);

    logic              buf_full;
    logic [DATA_W-1:0] buf_data;
    logic              pop;

    spi_tx_holdbuf #(
        .DATA_W (DATA_W)
    ) u_holdbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (tx_valid),
        .push_ready (tx_ready),
        .push_data  (tx_data),
        .pop        (pop),
        .buf_full   (buf_full),
        .buf_data   (buf_data)
    );

    // Frame laid out in transmission order: bit FL-1 goes out first.
    logic [FL-1:0] load_frame;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_frame
        if (MSB_FIRST) begin : g_msb
            assign load_frame[FL-DATA_W+gi] = buf_data[gi];
        end else begin : g_lsb
            assign load_frame[FL-1-gi] = buf_data[gi];
        end
    end

`ifdef SER_PARITY_EN
    assign load_frame[0] = ^buf_data;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FL-1:0] shreg_q, shreg_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (buf_full) begin
                    pop     = 1'b1;
                    shreg_d = load_frame;
                    cnt_d   = CNT_LAST;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (shift_en) begin
                    if (cnt_q != '0) begin
                        shreg_d = {shreg_q[FL-2:0], IDLE_LEVEL};
                        cnt_d   = cnt_q - CW'(1);
                    end else begin
                        done_d = 1'b1;
                        // A waiting word reloads on the same edge so no idle bit appears.
                        if (buf_full) begin
                            pop     = 1'b1;
                            shreg_d = load_frame;
                            cnt_d   = CNT_LAST;
                        end else begin
                            shreg_d = {FL{IDLE_LEVEL}};
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= {FL{IDLE_LEVEL}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    assign serial_out = shreg_q[FL-1];
    assign busy       = (state_q == ST_SHIFT);
    assign last_bit   = busy && (cnt_q == '0);
    assign done       = done_q;

endmodule
